// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Provides the ALU opcode encoding (aluop_t) and the types and constants used by the
// multi-cycle multiply/divide sequencer (muldiv_op_t, muldiv_state_t, MULDIV_ITER).
// Optional feature macro: MULDIV_SIGNED_EN adds the signed-divide fixup states.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_DIVU = 2'b01,
        OP_MUL  = 2'b10,
        OP_DIV  = 2'b11
    } muldiv_op_t;

    localparam int unsigned MULDIV_ITER  = 32;
    localparam int unsigned MULDIV_CNT_W = 5;

    typedef enum logic [3:0] {
        StIdle,
        StMulIt,
        StDivCmp,
        StDivUpd,
`ifdef MULDIV_SIGNED_EN
        StNegA,
        StNegB,
        StFixQ,
        StFixR,
`endif
        StDone
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_cnt.sv
// Iteration down-counter for the multiply/divide sequencer.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : preload the counter with ITER-1
//   dec      : decrement by one (saturates at zero)
//   zero     : high when the current iteration is the last one
module muldiv_iter_cnt
    import cpu_types_pkg::*;
#(
    parameter int unsigned ITER = MULDIV_ITER
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [MULDIV_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= MULDIV_CNT_W'(ITER - 1);
        end else if (dec && (count != '0)) begin
            count <= count - MULDIV_CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle integer multiply/divide sequencer.
// Borrows the shared single-cycle ALU (ADD/SUB/SLTU only) while busy is high.
// Multiply is shift-and-add over 32 cycles; divide is restoring division over 32
// compare/update pairs. Divide by zero finishes in one cycle.
// Ports:
//   CLK, RST              : clock, synchronous active-high reset (aborts any operation)
//   req_valid/req_ready   : request handshake; req_op 00 MULU, 01 DIVU, 10 MUL, 11 DIV
//   req_a, req_b          : multiplicand/dividend, multiplier/divisor
//   resp_valid/resp_ready : response handshake; result_lo = product/quotient,
//                           result_hi = 0/remainder
//   busy                  : high outside IDLE; pipeline routes the ALU to this block
//   alu_op, alu_a, alu_b  : ALU request; alu_out is the ALU result (same cycle)
// Optional feature macro: MULDIV_SIGNED_EN -- when defined, DIV is a signed divide
// (operand negation before, result fixup after); otherwise DIV behaves as DIVU.
module muldiv_seq
    import cpu_types_pkg::*;
#(
    parameter int unsigned XLEN = 32,  // only 32 supported
    parameter int unsigned ITER = 32   // must equal XLEN
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result_lo,
    output logic [XLEN-1:0] result_hi,
    output logic            busy,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_out
);

    muldiv_state_t   state;
    // opa: multiplicand, then dividend/quotient shift register
    // opb: multiplier, then divisor
    // acc: product accumulator, then partial remainder
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] acc;
    logic            ge;
`ifdef MULDIV_SIGNED_EN
    logic            sign_a;
    logic            sign_b;
    logic            signed_div;
`endif

    logic            is_mul;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_zero;
    logic [XLEN-1:0] rem_sh;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    assign is_mul    = (req_op == OP_MULU) || (req_op == OP_MUL);
    assign req_ready = (state == StIdle);
    assign busy      = (state != StIdle);
    assign cnt_load  = (state == StIdle) && req_valid;
    assign cnt_dec   = (state == StMulIt) || (state == StDivUpd);

    muldiv_iter_cnt #(
        .ITER (ITER)
    ) u_iter_cnt (
        .clk  (CLK),
        .rst  (RST),
        .load (cnt_load),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

    // Remainder shifted left with the next dividend bit; its dropped MSB (acc[XLEN-1])
    // means rem_sh >= divisor regardless of the 32-bit compare.
    assign rem_sh   = {acc[XLEN-2:0], opa[XLEN-1]};
    assign rem_next = ge ? alu_out : rem_sh;
    assign quo_next = {opa[XLEN-2:0], ge};

    // ALU drive decoded from registered state; idle/done keep ADD 0+0.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            StMulIt: begin
                alu_a = acc;
                alu_b = opb[0] ? opa : '0;
            end
            StDivCmp: begin
                alu_op = ALU_SLTU;
                alu_a  = rem_sh;
                alu_b  = opb;
            end
            StDivUpd: begin
                alu_op = ALU_SUB;
                alu_a  = rem_sh;
                alu_b  = opb;
            end
`ifdef MULDIV_SIGNED_EN
            StNegA: begin
                alu_op = ALU_SUB;
                alu_b  = opa;
            end
            StNegB: begin
                alu_op = ALU_SUB;
                alu_b  = opb;
            end
            StFixQ: begin
                alu_op = ALU_SUB;
                alu_b  = opa;
            end
            StFixR: begin
                alu_op = ALU_SUB;
                alu_b  = acc;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= StIdle;
            resp_valid <= 1'b0;
            result_lo  <= '0;
            result_hi  <= '0;
            opa        <= '0;
            opb        <= '0;
            acc        <= '0;
            ge         <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            signed_div <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        opa <= req_a;
                        opb <= req_b;
                        acc <= '0;
`ifdef MULDIV_SIGNED_EN
                        sign_a     <= req_a[XLEN-1];
                        sign_b     <= req_b[XLEN-1];
                        signed_div <= (req_op == OP_DIV);
`endif
                        if (is_mul) begin
                            state <= StMulIt;
                        end else if (req_b == '0) begin
                            result_lo  <= '1;
                            result_hi  <= req_a;
                            resp_valid <= 1'b1;
                            state      <= StDone;
                        end else begin
`ifdef MULDIV_SIGNED_EN
                            state <= (req_op == OP_DIV) ? StNegA : StDivCmp;
`else
                            state <= StDivCmp;
`endif
                        end
                    end
                end
                StMulIt: begin
                    acc <= alu_out;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    if (cnt_zero) begin
                        result_lo  <= alu_out;
                        result_hi  <= '0;
                        resp_valid <= 1'b1;
                        state      <= StDone;
                    end
                end
                StDivCmp: begin
                    // alu_out[0] = (rem_sh < divisor)
                    ge    <= acc[XLEN-1] | ~alu_out[0];
                    state <= StDivUpd;
                end
                StDivUpd: begin
                    acc <= rem_next;
                    opa <= quo_next;
                    if (!cnt_zero) begin
                        state <= StDivCmp;
`ifdef MULDIV_SIGNED_EN
                    end else if (signed_div) begin
                        state <= StFixQ;
`endif
                    end else begin
                        result_lo  <= quo_next;
                        result_hi  <= rem_next;
                        resp_valid <= 1'b1;
                        state      <= StDone;
                    end
                end
`ifdef MULDIV_SIGNED_EN
                // Negation always runs so the latency is data independent.
                StNegA: begin
                    if (sign_a) opa <= alu_out;
                    state <= StNegB;
                end
                StNegB: begin
                    if (sign_b) opb <= alu_out;
                    state <= StDivCmp;
                end
                StFixQ: begin
                    if (sign_a ^ sign_b) opa <= alu_out;
                    state <= StFixR;
                end
                StFixR: begin
                    // Remainder takes the sign of the dividend.
                    result_lo  <= opa;
                    result_hi  <= sign_a ? alu_out : acc;
                    resp_valid <= 1'b1;
                    state      <= StDone;
                end
`endif
                StDone: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        busy;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;

    always #5 CLK = ~CLK;

    muldiv_seq dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .busy       (busy),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out)
    );

    // Shared single-cycle ALU
    always_comb begin
        case (alu_op)
            4'(ALU_ADD):  alu_out = alu_a + alu_b;
            4'(ALU_SUB):  alu_out = alu_a - alu_b;
            4'(ALU_SLTU): alu_out = {31'b0, alu_a < alu_b};
            default:      alu_out = 32'hDEADBEEF;
        endcase
    end

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int unsigned lat;
        int unsigned due;
        bit          is_mul;
    } exp_t;

    exp_t        sbq[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned ecnt = 0;
    int          hold = 0;
    bit          seen = 0;
    int          busy_cyc = 0;
    int          add_cyc = 0;

    always @(posedge CLK) ecnt <= ecnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the operation's meaning.
    function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        e.is_mul = (op == 2'b00) || (op == 2'b10);
        if (e.is_mul) begin
            p     = {32'b0, a} * {32'b0, b};
            e.lo  = p[31:0];
            e.hi  = '0;
            e.lat = 33;
        end else if (b == 0) begin
            e.lo  = 32'hFFFFFFFF;
            e.hi  = a;
            e.lat = 1;
`ifdef MULDIV_SIGNED_EN
        end else if (op == 2'b11) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                e.lo = 32'h80000000;
                e.hi = '0;
            end else begin
                e.lo = 32'($signed(a) / $signed(b));
                e.hi = 32'($signed(a) % $signed(b));
            end
            e.lat = 69;
`endif
        end else begin
            e.lo  = a / b;
            e.hi  = a % b;
            e.lat = 65;
        end
        e.due = 0;
        return e;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        exp_t e;
        int   guard = 0;
        @(posedge CLK);
        #1;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        #2;
        while (!req_ready && guard < 500) begin
            @(posedge CLK);
            #3;
            guard++;
        end
        if (!req_ready) begin
            check("accept_timeout", {63'b0, req_ready}, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        if (push) begin
            e     = ref_model(op, a, b);
            e.due = ecnt + e.lat - 1;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sbq.size() != 0 && guard < 300) begin
            @(posedge CLK);
            guard++;
        end
        if (sbq.size() != 0) begin
            check("resp_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    // Consumer backpressure: forced-low window, otherwise random.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (hold > 0) begin
                resp_ready = 1'b0;
                if (resp_valid) hold--;
            end else begin
                resp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor / scoreboard checker
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (RST) begin
                seen     = 0;
                busy_cyc = 0;
                add_cyc  = 0;
                continue;
            end
            if (!busy || resp_valid) begin
                check("alu_quiet", {28'b0, alu_op, alu_a | alu_b}, {28'b0, 4'(ALU_ADD), 32'b0});
            end else begin
                busy_cyc++;
                if (alu_op == 4'(ALU_ADD)) add_cyc++;
            end
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_resp", {63'b0, resp_valid}, 64'd0);
                end else begin
                    if (!seen) begin
                        seen = 1;
                        check("latency", 64'(ecnt), 64'(sbq[0].due));
                    end
                    check("result_lo", {32'b0, result_lo}, {32'b0, sbq[0].lo});
                    check("result_hi", {32'b0, result_hi}, {32'b0, sbq[0].hi});
                    check("req_ready_in_done", {63'b0, req_ready}, 64'd0);
                    if (resp_ready) begin
                        check("busy_cycles", 64'(busy_cyc), 64'(sbq[0].lat - 1));
                        if (sbq[0].is_mul) check("mul_add_cycles", 64'(add_cyc), 64'd32);
                        void'(sbq.pop_front());
                        seen     = 0;
                        busy_cyc = 0;
                        add_cyc  = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          r;

        repeat (3) @(posedge CLK);
        #2;
        check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        check("rst_results", {result_hi, result_lo}, 64'd0);
        check("rst_busy_ready", {62'b0, busy, req_ready}, 64'd1);
        check("rst_alu", {28'b0, alu_op, alu_a | alu_b}, {28'b0, 4'(ALU_ADD), 32'b0});
        RST = 1'b0;

        issue(2'b00, 32'd7, 32'd6, 1);
        drain();
        hold = 5;
        issue(2'b10, 32'hFFFFFFFF, 32'd2, 1);
        drain();
        issue(2'b01, 32'd100, 32'd7, 1);
        drain();
        issue(2'b01, 32'hFFFFFFFF, 32'd3, 1);
        drain();
        issue(2'b01, 32'd5, 32'd0, 1);
        drain();
        issue(2'b11, 32'hFFFFFFF9, 32'd2, 1);
        drain();
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 1);
        drain();
        issue(2'b11, 32'h12345678, 32'd0, 1);
        drain();

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            else if (r <= 3) b = 32'($urandom_range(1, 15));
            else if (r == 4) b = 32'hFFFFFFFF;
            else b = $urandom;
            issue(op, a, b, 1);
            drain();
        end

        // Abort a DIVU mid-flight with a reset in cycle k+10
        issue(2'b01, 32'd1000, 32'd7, 0);
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_resp_valid", {63'b0, resp_valid}, 64'd0);
        check("abort_req_ready", {63'b0, req_ready}, 64'd1);
        issue(2'b00, 32'd3, 32'd3, 1);
        drain();

        repeat (3) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
